// File: rtl/vram_arb.sv
// VRAM arbiter: shares one synchronous RAM between game-logic writes and
// per-line display fetches into a line buffer. Fetches always win over writes.
module vram_arb #(
   parameter int ADDR_W      = 12,
   parameter int DATA_W      = 16,
   parameter int FETCH_WORDS = 40
) (
   input  logic              sys_clk,
   input  logic              reset,
   input  logic              EndLine,
   input  logic              fetch_en,
   input  logic [ADDR_W-1:0] fetch_base,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [DATA_W-1:0] wr_data,
   output logic              wr_ack,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_we,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              lb_we,
   output logic [7:0]        lb_addr,
   output logic [DATA_W-1:0] lb_data,
   output logic              fetch_done,
   output logic              overrun
);

   typedef enum logic [1:0] {IDLE, WRITE, FETCH, DRAIN} state_t;

   localparam logic [7:0] LAST_CNT = 8'(FETCH_WORDS - 1);

   state_t            r_state;
   state_t            w_nextState;
   logic              r_fetchPending;
   logic [ADDR_W-1:0] r_baseQ;
   logic [7:0]        r_cnt;
   logic [7:0]        r_rdCnt;
   logic              r_rdValid;
   logic              r_overrun;
   logic [ADDR_W-1:0] r_ramAddr;
   logic              r_ramWe;
   logic [DATA_W-1:0] r_ramWdata;

   logic              w_newLine;
   logic              w_restart;
   logic              w_lastRead;
   logic [7:0]        w_nextCnt;
   logic [ADDR_W-1:0] w_fetchBase;

   // A new line arriving while a fetch is still running restarts it on the new base.
   assign w_newLine   = EndLine & fetch_en;
   assign w_restart   = w_newLine & ((r_state == FETCH) | (r_state == DRAIN));
   assign w_lastRead  = (r_cnt == LAST_CNT);
   assign w_fetchBase = w_restart ? fetch_base : r_baseQ;
   assign w_nextCnt   = ((r_state == FETCH) && !w_restart) ? r_cnt + 8'd1 : 8'd0;

   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_nextState;
      end
   end

   // A write is not started in the same cycle a new line is announced.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (r_fetchPending) begin
               w_nextState = FETCH;
            end else if (wr_req && !w_newLine) begin
               w_nextState = WRITE;
            end
         end
         WRITE: w_nextState = IDLE;
         FETCH: begin
            if (w_restart) begin
               w_nextState = FETCH;
            end else if (w_lastRead) begin
               w_nextState = DRAIN;
            end
         end
         DRAIN: w_nextState = w_restart ? FETCH : IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // RAM address/enables are registered on entry so they line up with the state they belong to.
   always_ff @(posedge sys_clk or posedge reset) begin
      if (reset) begin
         r_fetchPending <= 1'b0;
         r_baseQ        <= '0;
         r_cnt          <= 8'd0;
         r_rdCnt        <= 8'd0;
         r_rdValid      <= 1'b0;
         r_overrun      <= 1'b0;
         r_ramAddr      <= '0;
         r_ramWe        <= 1'b0;
         r_ramWdata     <= '0;
      end else begin
         if (w_newLine) begin
            r_baseQ <= fetch_base;
         end
         if (w_newLine && !w_restart) begin
            r_fetchPending <= 1'b1;
         end else if ((r_state == IDLE) && r_fetchPending) begin
            r_fetchPending <= 1'b0;
         end
         r_cnt <= (w_nextState == FETCH) ? w_nextCnt : 8'd0;
         if (w_nextState == WRITE) begin
            r_ramAddr  <= wr_addr;
            r_ramWdata <= wr_data;
         end else if (w_nextState == FETCH) begin
            r_ramAddr <= w_fetchBase + ADDR_W'(w_nextCnt);
         end
         r_ramWe   <= (w_nextState == WRITE);
         r_rdValid <= (r_state == FETCH);
         if (r_state == FETCH) begin
            r_rdCnt <= r_cnt;
         end
         if (w_restart) begin
            r_overrun <= 1'b1;
         end
      end
   end

   always_comb begin
      wr_ack     = (r_state == WRITE);
      fetch_done = (r_state == DRAIN) && !w_restart;
      lb_we      = r_rdValid;
      lb_addr    = r_rdCnt;
      lb_data    = r_rdValid ? ram_rdata : '0;
   end

   assign ram_addr  = r_ramAddr;
   assign ram_we    = r_ramWe;
   assign ram_wdata = r_ramWdata;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_vram_arb.sv
// Directed bench for vram_arb with FETCH_WORDS=4: a line-buffer scoreboard
// fed at stimulus time and drained by a monitor, plus cycle-exact checks.
module tb_vram_arb;

   logic        sys_clk;
   logic        reset;
   logic        EndLine;
   logic        fetch_en;
   logic [11:0] fetch_base;
   logic        wr_req;
   logic [11:0] wr_addr;
   logic [15:0] wr_data;
   logic        wr_ack;
   logic [11:0] ram_addr;
   logic        ram_we;
   logic [15:0] ram_wdata;
   logic [15:0] ram_rdata;
   logic        lb_we;
   logic [7:0]  lb_addr;
   logic [15:0] lb_data;
   logic        fetch_done;
   logic        overrun;

   int          nTests = 0;
   int          nFail = 0;
   int          doneCount = 0;
   int          ackCount = 0;
   int          doneMark;
   int          ackMark;
   logic [23:0] expQ[$];

   vram_arb #(.ADDR_W(12), .DATA_W(16), .FETCH_WORDS(4)) dut (
      .sys_clk(sys_clk), .reset(reset), .EndLine(EndLine), .fetch_en(fetch_en),
      .fetch_base(fetch_base), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
      .wr_ack(wr_ack), .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
      .ram_rdata(ram_rdata), .lb_we(lb_we), .lb_addr(lb_addr), .lb_data(lb_data),
      .fetch_done(fetch_done), .overrun(overrun)
   );

   initial sys_clk = 1'b0;
   always #5 sys_clk = ~sys_clk;

   function automatic logic [15:0] memf(input logic [11:0] a);
      return {4'h5, a} ^ 16'h0F0F;
   endfunction

   // Synchronous RAM model: data for an address appears one cycle later.
   always @(posedge sys_clk) ram_rdata <= memf(ram_addr);

   always @(negedge sys_clk) begin
      if (fetch_done) doneCount++;
      if (wr_ack) ackCount++;
      if (lb_we) begin
         nTests++;
         assert (expQ.size() != 0) else begin
            nFail++;
            $error("[TB] FAIL lb_unexpected observed addr=%0h data=%0h expected no write", lb_addr, lb_data);
         end
         if (expQ.size() != 0) begin
            logic [23:0] e;
            e = expQ.pop_front();
            nTests++;
            assert ({lb_addr, lb_data} === e) else begin
               nFail++;
               $error("[TB] FAIL lb_write observed=%0h expected=%0h", {lb_addr, lb_data}, e);
            end
         end
      end
   end

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nTests++;
      assert (obs === exp) else begin
         nFail++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic applyStimulus(input logic el, input logic fe, input logic [11:0] base,
                                input logic wr, input logic [11:0] wa, input logic [15:0] wd);
      EndLine    = el;
      fetch_en   = fe;
      fetch_base = base;
      wr_req     = wr;
      wr_addr    = wa;
      wr_data    = wd;
   endtask

   task automatic pushLine(input logic [11:0] base, input int n);
      for (int i = 0; i < n; i++) begin
         logic [11:0] a;
         a = base + 12'(i);
         expQ.push_back({8'(i), memf(a)});
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_ram_addr"}, ram_addr, 0);
      checkOutput({tag, "_ram_we"}, ram_we, 0);
      checkOutput({tag, "_ram_wdata"}, ram_wdata, 0);
      checkOutput({tag, "_wr_ack"}, wr_ack, 0);
      checkOutput({tag, "_lb_we"}, lb_we, 0);
      checkOutput({tag, "_lb_addr"}, lb_addr, 0);
      checkOutput({tag, "_lb_data"}, lb_data, 0);
      checkOutput({tag, "_fetch_done"}, fetch_done, 0);
      checkOutput({tag, "_overrun"}, overrun, 0);
   endtask

   // Runs a full line from an IDLE arbiter and checks addresses and completion timing.
   task automatic plainFetch(input string tag, input logic [11:0] base);
      logic [11:0] a;
      pushLine(base, 4);
      doneMark = doneCount;
      applyStimulus(1, 1, base, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         a = base + 12'(i);
         checkOutput($sformatf("%s_addr%0d", tag, i), ram_addr, a);
         checkOutput($sformatf("%s_we%0d", tag, i), ram_we, 0);
      end
      tick();
      checkOutput({tag, "_done"}, fetch_done, 1);
      checkOutput({tag, "_done_late"}, doneMark, doneCount);
      tick();
      checkOutput({tag, "_done_pulse"}, fetch_done, 0);
      checkOutput({tag, "_addr_hold"}, ram_addr, a);
      checkOutput({tag, "_lb_drained"}, expQ.size(), 0);
   endtask

   initial begin
      reset = 1'b1;
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkAllZero("reset");
      reset = 1'b0;
      tick();

      plainFetch("plain", 12'h100);

      // A line marker with fetch disabled must leave the arbiter idle.
      doneMark = doneCount;
      applyStimulus(1, 0, 12'h777, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 7; i++) tick();
      checkOutput("noen_addr", ram_addr, 12'h103);
      checkOutput("noen_done", doneCount, doneMark);

      plainFetch("wrap", 12'hFFE);

      ackMark = ackCount;
      applyStimulus(0, 0, 0, 1, 12'h010, 16'hBEEF);
      tick();
      checkOutput("wr1_ack", wr_ack, 1);
      checkOutput("wr1_we", ram_we, 1);
      checkOutput("wr1_addr", ram_addr, 12'h010);
      checkOutput("wr1_data", ram_wdata, 16'hBEEF);
      tick();
      checkOutput("wr1_gap_ack", wr_ack, 0);
      checkOutput("wr1_gap_we", ram_we, 0);
      tick();
      checkOutput("wr2_ack", wr_ack, 1);
      checkOutput("wr2_we", ram_we, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("wr2_gap_ack", wr_ack, 0);
      tick();
      checkOutput("wr_stop_ack", wr_ack, 0);
      checkOutput("wr_ack_count", ackCount - ackMark, 2);

      // Write and line marker together: the fetch must run to completion first.
      pushLine(12'h300, 4);
      applyStimulus(1, 1, 12'h300, 1, 12'h020, 16'h1234);
      tick();
      applyStimulus(0, 0, 0, 1, 12'h020, 16'h1234);
      checkOutput("prio_c1_ack", wr_ack, 0);
      for (int i = 0; i < 4; i++) begin
         tick();
         checkOutput($sformatf("prio_addr%0d", i), ram_addr, 12'h300 + 12'(i));
         checkOutput($sformatf("prio_ack%0d", i), wr_ack, 0);
      end
      tick();
      checkOutput("prio_done", fetch_done, 1);
      checkOutput("prio_drain_ack", wr_ack, 0);
      tick();
      checkOutput("prio_idle_ack", wr_ack, 0);
      tick();
      checkOutput("prio_wr_ack", wr_ack, 1);
      checkOutput("prio_wr_addr", ram_addr, 12'h020);
      checkOutput("prio_wr_data", ram_wdata, 16'h1234);
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("prio_after_ack", wr_ack, 0);
      checkOutput("prio_lb_drained", expQ.size(), 0);

      // Second line marker lands while the read with cnt=2 is on the bus.
      pushLine(12'h400, 3);
      pushLine(12'h200, 4);
      doneMark = doneCount;
      applyStimulus(1, 1, 12'h400, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      checkOutput("ovr_a0", ram_addr, 12'h400);
      tick();
      checkOutput("ovr_a1", ram_addr, 12'h401);
      tick();
      checkOutput("ovr_a2", ram_addr, 12'h402);
      checkOutput("ovr_flag_before", overrun, 0);
      applyStimulus(1, 1, 12'h200, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("ovr_flag", overrun, 1);
      checkOutput("ovr_b0", ram_addr, 12'h200);
      checkOutput("ovr_old_lb_we", lb_we, 1);
      checkOutput("ovr_old_lb_addr", lb_addr, 2);
      for (int i = 1; i < 4; i++) begin
         tick();
         checkOutput($sformatf("ovr_b%0d", i), ram_addr, 12'h200 + 12'(i));
      end
      checkOutput("ovr_no_done", doneCount, doneMark);
      tick();
      checkOutput("ovr_done", fetch_done, 1);
      for (int i = 0; i < 4; i++) tick();
      checkOutput("ovr_sticky", overrun, 1);
      checkOutput("ovr_lb_drained", expQ.size(), 0);

      // Reset while the read with cnt=1 is on the bus discards the whole line.
      doneMark = doneCount;
      applyStimulus(1, 1, 12'h500, 0, 0, 0);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 0);
      tick();
      tick();
      checkOutput("rst_pre_addr", ram_addr, 12'h501);
      reset = 1'b1;
      #1;
      checkAllZero("midrst");
      tick();
      reset = 1'b0;
      for (int i = 0; i < 8; i++) tick();
      checkOutput("midrst_no_done", doneCount, doneMark);
      checkOutput("midrst_lb_empty", expQ.size(), 0);
      checkOutput("midrst_overrun", overrun, 0);

      plainFetch("post_rst", 12'h040);
      tick();
      tick();
      checkOutput("final_lb_drained", expQ.size(), 0);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/vram_arb.md
VRAM_ARB -- requirements
Module: vram_arb

Interface
REQ-001 Parameters SHALL be ADDR_W = 12 (RAM address width), DATA_W = 16 (RAM data width), FETCH_WORDS = 40 (words fetched per display line, 2..255).
REQ-002 Ports SHALL be, in this order:
- sys_clk, in, 1: the single clock.
- reset, in, 1: asynchronous, active-high.
- EndLine, in, 1: one-cycle pulse at the end of each scan line.
- fetch_en, in, 1: sampled with EndLine; 1 means the next line is active.
- fetch_base, in, ADDR_W: first RAM address of the next line; sampled with EndLine.
- wr_req, in, 1: game-logic write request.
- wr_addr, in, ADDR_W: write address.
- wr_data, in, DATA_W: write data.
- wr_ack, out, 1: one-cycle pulse when the write is performed.
- ram_addr, out, ADDR_W: RAM address (registered).
- ram_we, out, 1: RAM write enable (registered).
- ram_wdata, out, DATA_W: RAM write data (registered).
- ram_rdata, in, DATA_W: RAM read data, valid 1 cycle after ram_addr.
- lb_we, out, 1: line-buffer write enable.
- lb_addr, out, 8: line-buffer word index.
- lb_data, out, DATA_W: line-buffer write data.
- fetch_done, out, 1: one-cycle pulse after the last line-buffer write.
- overrun, out, 1: sticky error flag.

Function
REQ-003 The FSM SHALL have four states: IDLE, WRITE, FETCH and DRAIN.
REQ-004 On EndLine=1 with fetch_en=1, the block SHALL set fetch_pending and latch fetch_base into base_q. EndLine with fetch_en=0 SHALL have no effect.
REQ-005 IDLE with fetch_pending=1 SHALL go to FETCH and clear fetch_pending. Fetch SHALL have strict priority over writes.
REQ-006 IDLE with fetch_pending=0 and wr_req=1 SHALL go to WRITE, registering ram_addr=wr_addr, ram_wdata=wr_data and ram_we=1.
REQ-007 WRITE SHALL last exactly one cycle:
- ram_we=1 and wr_ack=1 in that cycle.
- The next state SHALL be IDLE.
REQ-008 The write handshake SHALL follow these rules:
- The requester holds wr_req, wr_addr and wr_data stable until wr_ack.
- A wr_req still high in the cycle after wr_ack SHALL be treated as a new request.
- Peak write throughput SHALL be one write per 2 cycles.
REQ-009 FETCH SHALL issue FETCH_WORDS consecutive reads, one per cycle:
- ram_addr = base_q + cnt, with cnt = 0..FETCH_WORDS-1.
- ram_we=0.
- The sum SHALL wrap modulo 2^ADDR_W.
REQ-010 Each read's ram_rdata SHALL be written one cycle later with lb_we=1, lb_addr = cnt of that read, lb_data = ram_rdata.
REQ-011 After the read with cnt=FETCH_WORDS-1 the FSM SHALL enter DRAIN for exactly one cycle:
- The last lb_we occurs in the DRAIN cycle.
- fetch_done=1 in the DRAIN cycle.
- The next state SHALL be IDLE.
REQ-012 Fetch latency SHALL be:
- First ram_addr 2 cycles after EndLine if the block was IDLE.
- fetch_done FETCH_WORDS+2 cycles after EndLine.
REQ-013 EndLine during WRITE SHALL let the write complete. FETCH SHALL then start after 1 IDLE cycle.
REQ-014 EndLine with fetch_en=1 during FETCH or DRAIN SHALL:
- Set overrun=1 (sticky until reset).
- Abort the current fetch with no fetch_done.
- Latch the new base.
- Go to FETCH with cnt=0 on the next cycle.
The one pending lb_we from the aborted read SHALL still be emitted.
REQ-015 In states other than WRITE and FETCH, ram_we SHALL be 0 and ram_addr SHALL hold its last value.
REQ-016 wr_ack, lb_we and fetch_done SHALL each be single-cycle pulses. They SHALL never be asserted outside the conditions above.

Reset
REQ-017 Asserting reset SHALL immediately set:
- state=IDLE, fetch_pending=0, cnt=0, base_q=0.
- ram_addr=0, ram_we=0, ram_wdata=0.
- wr_ack=0, lb_we=0, lb_addr=0, lb_data=0, fetch_done=0, overrun=0.
REQ-018 Reset mid-fetch or mid-write SHALL discard all pending work. The first EndLine after deassertion SHALL be handled normally.

Verification (FETCH_WORDS=4, ADDR_W=12)
REQ-019 Plain fetch: EndLine with fetch_en=1, fetch_base=0x100, no writes -> ram_addr 0x100..0x103 on consecutive cycles; lb_we×4 with lb_addr 0..3 carrying the data; fetch_done at EndLine+6.
REQ-020 Wrap: fetch_base=0xFFE -> ram_addr 0xFFE, 0xFFF, 0x000, 0x001.
REQ-021 Writes: wr_req held high with addr 0x010, data 0xBEEF -> ram_we=1 at 0x010 with 0xBEEF; wr_ack every 2nd cycle while wr_req is held.
REQ-022 Priority: wr_req and EndLine arrive in the same IDLE cycle -> fetch of 4 words completes first; the write is acked only after DRAIN.
REQ-023 Overrun: second EndLine (fetch_en=1, base=0x200) at read cnt=2 -> overrun=1; no fetch_done for the first fetch; reads 0x200..0x203 follow; overrun stays 1 until reset.
REQ-024 Reset mid-fetch: reset at cnt=1 -> all outputs 0 immediately; no further lb_we or fetch_done until the next EndLine.
